dca_matrix_lsu_responder: RTL
=============================

DCA_MATRIX_LSU_RESPONDER -- requirements
Module: dca_matrix_lsu_responder

Interface
REQ-001 SHALL provide the following parameters (name, default, meaning):
- BW_ADDR, 32, memory byte address width.
- BW_ROW, 256, data width of one matrix row.
- DEPTH, 4, maximum rows in flight; a power of two, at least 2.
REQ-002 SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rstnn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush.
- enable  in  1  global advance enable.
- inst_valid  in  1  LSU instruction offered.
- inst_ready  out  1  LSU instruction accepted.
- inst  in  BW_ADDR+16+4+2  fields {base_addr, stride[15:0], nrow[3:0], opcode[1:0]}; opcode 0=READ, 1=WRITE, 2..3 reserved.
- rdata_valid  out  1  load row to consumer.
- rdata_ready  in  1  consumer accepts the load row.
- rdata  out  BW_ROW  load row data.
- rdata_last  out  1  final row of a READ instruction.
- wdata_valid  in  1  store row from producer.
- wdata_ready  out  1  store row accepted.
- wdata  in  BW_ROW  store row data.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_write  out  1  1=write, 0=read.
- mem_req_addr  out  BW_ADDR  row address.
- mem_req_wdata  out  BW_ROW  write data.
- mem_rsp_valid  in  1  read response; no backpressure; responses return in order.
- mem_rsp_data  in  BW_ROW  read response data.
- idle  out  1  FSM in IDLE, buffer empty, and no reads outstanding.

Function
REQ-003 SHALL implement FSM states IDLE, RD_ISSUE, WR_ISSUE.
REQ-004 SHALL drive inst_ready=1 only in IDLE with enable=1; handshake inst_valid&inst_ready latches the inst fields, row index=0, and moves to RD_ISSUE (opcode 0) or WR_ISSUE (opcode 1).
REQ-005 SHALL treat reserved opcodes as accepted and discarded: no memory traffic; FSM stays IDLE.
REQ-006 SHALL treat nrow=0 as 16 rows and nrow=1..15 as that many rows.
REQ-007 SHALL form row i's address as base_addr + i*stride, with stride zero-extended and the result truncated to BW_ADDR (modulo wrap-around, no error).
REQ-008 In RD_ISSUE, SHALL assert mem_req_valid (mem_req_write=0) only while outstanding+occupancy < DEPTH, where outstanding = accepted reads not yet responded and occupancy = rows buffered.
REQ-009 SHALL advance the row index on mem_req_valid&mem_req_ready, and return to IDLE on the final row's handshake.
REQ-010 In WR_ISSUE, SHALL set mem_req_valid=wdata_valid, wdata_ready=mem_req_ready, mem_req_write=1, mem_req_wdata=wdata (combinational pass-through, zero latency); writes generate no response; returns to IDLE on the final row's handshake.
REQ-011 SHALL push each mem_rsp_valid into a DEPTH-entry FIFO, tagging the entry last=1 when it answers the final read request of an instruction; the buffer can never overflow by construction of REQ-008.
REQ-012 SHALL present the FIFO head as rdata/rdata_last with rdata_valid=not empty; the head pops on rdata_valid&rdata_ready.
REQ-013 SHALL allow a push and a pop in the same cycle when full or empty (pass-through not required; minimum response-to-rdata_valid latency is 1 cycle).
REQ-014 SHALL allow a new instruction to be accepted while earlier read rows are still outstanding or buffered.
REQ-015 While enable=0, SHALL freeze all state and force inst_ready, mem_req_valid, wdata_ready, rdata_valid to 0; mem_rsp_valid SHALL still be captured into the FIFO.
REQ-016 On clear=1 (precedence over enable), SHALL in the next cycle: FSM to IDLE; FIFO emptied; row index 0; the outstanding count moved to a discard counter, whose responses are dropped and which decrements per mem_rsp_valid; idle=0 until the discard counter reaches 0.
REQ-017 SHALL handle a simultaneous request handshake and response: the outstanding count is unchanged.

Reset
REQ-018 On rstnn=0, SHALL asynchronously set: FSM=IDLE; all counters 0; FIFO empty; inst_ready=0 while enable=0; rdata_valid=0; rdata_last=0; mem_req_valid=0; mem_req_write=0; wdata_ready=0; idle=1; rdata/mem_req_addr=0.
REQ-019 Reset deasserted mid-transfer SHALL leave no residual requests or data.

Verification
REQ-020 READ base=0x1000, stride=0x20, nrow=3, memory ready, 1-cycle response -> mem_req_addr 0x1000, 0x1020, 0x1040; three rdata rows in order, rdata_last on the third only; idle returns to 1.
REQ-021 READ nrow=8, DEPTH=4, rdata_ready=0 -> exactly 4 requests issued, then mem_req_valid held 0; releasing rdata_ready resumes issue, one request per freed slot.
REQ-022 WRITE nrow=2 with wdata_valid gapped and mem_req_ready toggling -> exactly 2 write requests carrying the matching wdata, no rdata; FSM back to IDLE.
REQ-023 Back-to-back READ nrow=1 then READ nrow=2 -> second inst accepted before the first row is consumed; rdata_last on rows 1 and 3.
REQ-024 clear with 2 reads outstanding -> both late responses dropped; rdata_valid stays 0; idle=1 after the second response.
REQ-025 base=0xFFFFFFF0, stride=0x20, nrow=2 -> addresses 0xFFFFFFF0, 0x00000010; reserved opcode 3 -> accepted, no mem_req_valid.

Source files
------------

// File: rtl/dca_matrix_lsu_responder.sv
// Matrix LSU responder: turns strided row instructions into memory requests
// and buffers in-order read responses for the row consumer.
module dca_matrix_lsu_responder #(
   parameter int BW_ADDR = 32,
   parameter int BW_ROW  = 256,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rstnn,
   input  logic               clear,
   input  logic               enable,
   input  logic               inst_valid,
   output logic               inst_ready,
   input  logic [BW_ADDR+21:0] inst,
   output logic               rdata_valid,
   input  logic               rdata_ready,
   output logic [BW_ROW-1:0]  rdata,
   output logic               rdata_last,
   input  logic               wdata_valid,
   output logic               wdata_ready,
   input  logic [BW_ROW-1:0]  wdata,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic               mem_req_write,
   output logic [BW_ADDR-1:0] mem_req_addr,
   output logic [BW_ROW-1:0]  mem_req_wdata,
   input  logic               mem_rsp_valid,
   input  logic [BW_ROW-1:0]  mem_rsp_data,
   output logic               idle
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = AW + 4;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_ISSUE} state_t;

   state_t state, state_n;

   logic [BW_ADDR-1:0] addr_q;
   logic [15:0]        stride_q;
   logic [4:0]         nrow_q;
   logic [4:0]         row_q;
   logic [CW-1:0]      out_q;
   logic [CW-1:0]      wp_q;
   logic [CW-1:0]      rp_q;
   logic [CW-1:0]      occ;
   logic [AW-1:0]      tp_q;
   logic [DW-1:0]      dis_q;
   logic [DEPTH-1:0]   last_mem;
   logic [BW_ROW-1:0]  data_mem [DEPTH];

   logic        act;
   logic        accept;
   logic        req_hs;
   logic        rd_hs;
   logic        row_last;
   logic        empty;
   logic        rsp_keep;
   logic        pop;
   logic        room;
   logic [CW:0] in_use;
   logic [4:0]  inst_nrow;

   assign act       = enable & ~clear;
   assign occ       = wp_q - rp_q;
   assign empty     = (occ == '0);
   assign in_use    = {1'b0, out_q} + {1'b0, occ};
   assign room      = (in_use < DEPTH_C);
   assign row_last  = (row_q == nrow_q - 5'd1);
   assign rsp_keep  = mem_rsp_valid & (dis_q == '0);
   assign accept    = inst_valid & inst_ready;
   assign req_hs    = mem_req_valid & mem_req_ready;
   assign rd_hs     = req_hs & (state == RD_ISSUE);
   assign pop       = rdata_valid & rdata_ready;
   assign inst_nrow = (inst[5:2] == 4'd0) ? 5'd16 : {1'b0, inst[5:2]};

   assign mem_req_addr = addr_q;
   assign rdata_valid  = act & ~empty;
   assign rdata        = empty ? '0 : data_mem[rp_q[AW-1:0]];
   assign rdata_last   = ~empty & last_mem[rp_q[AW-1:0]];
   assign idle = (state == IDLE) & empty & (out_q == '0) & (dis_q == '0);

   always_comb begin
      state_n       = state;
      inst_ready    = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      mem_req_wdata = '0;
      wdata_ready   = 1'b0;
      unique case (state)
         IDLE: begin
            inst_ready = act;
            if (accept) begin
               unique case (1'b1)
                  (inst[1:0] == 2'd0): state_n = RD_ISSUE;
                  (inst[1:0] == 2'd1): state_n = WR_ISSUE;
                  default:             state_n = IDLE;
               endcase
            end
         end
         RD_ISSUE: begin
            mem_req_valid = act & room;
            if (req_hs & row_last) state_n = IDLE;
         end
         WR_ISSUE: begin
            mem_req_valid = act & wdata_valid;
            wdata_ready   = act & mem_req_ready;
            mem_req_write = 1'b1;
            mem_req_wdata = wdata;
            if (req_hs & row_last) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (clear) state_n = IDLE;
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state    <= IDLE;
         addr_q   <= '0;
         stride_q <= '0;
         nrow_q   <= 5'd1;
         row_q    <= '0;
         out_q    <= '0;
         wp_q     <= '0;
         rp_q     <= '0;
         tp_q     <= '0;
         dis_q    <= '0;
         last_mem <= '0;
      end else begin
         state <= state_n;
         if (clear) begin
            row_q <= '0;
            out_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            tp_q  <= '0;
            // in-flight reads become dropped responses
            dis_q <= dis_q + DW'(out_q) - DW'(mem_rsp_valid);
         end else begin
            if (accept) begin
               addr_q   <= inst[BW_ADDR+21:22];
               stride_q <= inst[21:6];
               nrow_q   <= inst_nrow;
               row_q    <= '0;
            end else if (req_hs) begin
               addr_q <= addr_q + BW_ADDR'(stride_q);
               row_q  <= row_q + 5'd1;
            end
            // last tag reserved in the slot this response will land in
            if (rd_hs) begin
               last_mem[tp_q] <= row_last;
               tp_q           <= tp_q + 1'b1;
            end
            out_q <= out_q + CW'(rd_hs) - CW'(rsp_keep);
            if (mem_rsp_valid & (dis_q != '0)) dis_q <= dis_q - 1'b1;
            if (rsp_keep) wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rsp_keep & ~clear) data_mem[wp_q[AW-1:0]] <= mem_rsp_data;
   end

endmodule
